ew_wptr_full: RTL and testbench

//  Write-side pointer/flag generator of the async FIFO. Owns the write pointer in the write clock domain and

---
 rtl/ew_fifo_pkg.sv | 27 ++
 rtl/ew_gray_cnt.sv | 40 ++++
 rtl/ew_wptr_full.sv | 88 ++++++++
 tb/tb_ew_wptr_full.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ew_fifo_pkg.sv
// Shared async-FIFO helpers: pointer width rule and Gray/binary conversion.
// Used by both the write-side and read-side pointer blocks.
package ew_fifo_pkg;

    localparam int unsigned GVEC_W = 32;
    typedef logic [GVEC_W-1:0] gvec_t;

    // Pointers carry one extra bit so full and empty can be told apart.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    // Width-independent: callers zero-extend into gvec_t and truncate the result.
    function automatic gvec_t bin2gray(input gvec_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gvec_t gray2bin(input gvec_t g);
        gvec_t b;
        b = g;
        for (int i = 1; i < GVEC_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/ew_gray_cnt.sv
// Binary counter with a registered Gray copy; the Gray flop is the only
// value allowed to cross clock domains, so it is never driven by logic.
module ew_gray_cnt
    import ew_fifo_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init_n,
    input  logic         en_i,
    output logic [W-1:0] bin_nxt_o,
    output logic [W-1:0] bin_o,
    output logic [W-1:0] gray_o
);

    logic [W-1:0] bin_q;
    logic [W-1:0] gray_q;
    logic [W-1:0] gray_d;

    assign bin_nxt_o = en_i ? bin_q + W'(1) : bin_q;
    assign gray_d    = W'(bin2gray(gvec_t'(bin_nxt_o)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else if (!init_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_nxt_o;
            gray_q <= gray_d;
        end
    end

    assign bin_o  = bin_q;
    assign gray_o = gray_q;

endmodule

// File: rtl/ew_wptr_full.sv
// Write-side pointer and flag generator of the async FIFO. Flags are computed
// against the synchronized (late) read pointer, so they err toward "fuller".
module ew_wptr_full
    import ew_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AFULL_LVL  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_n,
    input  logic                  push_i,
    input  logic [ADDR_WIDTH:0]   rptr_gray_i,
    output logic                  wen_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [ADDR_WIDTH:0]   wptr_gray_o,
    output logic                  full_o,
    output logic                  afull_o,
    output logic [ADDR_WIDTH:0]   wcount_o,
    output logic                  overflow_o
);

    localparam int unsigned PW    = ptr_width(ADDR_WIDTH);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AFULL_TH  = PW'(DEPTH - AFULL_LVL);
    // Full when the write pointer is the read pointer with its top two Gray bits inverted.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    logic          accept;
    logic [PW-1:0] wbin_nxt, wbin, wgray;
    logic [PW-1:0] wgray_nxt, rbin, diff;
    logic          full_d, afull_d, ovf_d;
    logic [PW-1:0] wcount_d;
    logic          full_q, afull_q, ovf_q;
    logic [PW-1:0] wcount_q;
    logic          unused_wbin_msb;

    assign accept = push_i & ~full_q & init_n;
    assign wen_o  = accept;

    ew_gray_cnt #(.W(PW)) u_wcnt (
        .clk      (clk),
        .rst      (rst),
        .init_n   (init_n),
        .en_i     (accept),
        .bin_nxt_o(wbin_nxt),
        .bin_o    (wbin),
        .gray_o   (wgray)
    );

    always_comb begin
        wgray_nxt = PW'(bin2gray(gvec_t'(wbin_nxt)));
        rbin      = PW'(gray2bin(gvec_t'(rptr_gray_i)));
        diff      = wbin_nxt - rbin;
        full_d    = (wgray_nxt == (rptr_gray_i ^ FULL_MASK));
        afull_d   = (diff >= AFULL_TH);
        wcount_d  = diff;
        ovf_d     = push_i & full_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            wcount_q <= '0;
            ovf_q    <= 1'b0;
        end else if (!init_n) begin
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            wcount_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            full_q   <= full_d;
            afull_q  <= afull_d;
            wcount_q <= wcount_d;
            ovf_q    <= ovf_d;
        end
    end

    assign waddr_o         = wbin[ADDR_WIDTH-1:0];
    assign unused_wbin_msb = wbin[PW-1];
    assign wptr_gray_o     = wgray;
    assign full_o          = full_q;
    assign afull_o         = afull_q;
    assign wcount_o        = wcount_q;
    assign overflow_o      = ovf_q;

endmodule

// File: tb/tb_ew_wptr_full.sv
// Directed bench for ew_wptr_full (ADDR_WIDTH=2, AFULL_LVL=1): stimulus queues
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_ew_wptr_full;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_n = 1'b1;
    logic       push_i = 1'b0;
    logic [2:0] rptr_gray_i = 3'b000;
    logic       wen_o;
    logic [1:0] waddr_o;
    logic [2:0] wptr_gray_o;
    logic       full_o, afull_o, overflow_o;
    logic [2:0] wcount_o;

    typedef struct {
        string      name;
        logic [2:0] gray;
        logic [1:0] waddr;
        logic       full;
        logic       afull;
        logic [2:0] wcount;
        logic       ovf;
        bit         chk1;
    } exp_t;

    exp_t q[$];
    int   n_tot  = 0;
    int   n_pass = 0;
    logic [2:0] prev_gray = 3'b000;

    ew_wptr_full #(.ADDR_WIDTH(2), .AFULL_LVL(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .init_n     (init_n),
        .push_i     (push_i),
        .rptr_gray_i(rptr_gray_i),
        .wen_o      (wen_o),
        .waddr_o    (waddr_o),
        .wptr_gray_o(wptr_gray_o),
        .full_o     (full_o),
        .afull_o    (afull_o),
        .wcount_o   (wcount_o),
        .overflow_o (overflow_o)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " outputs"},
            {21'd0, waddr_o, wptr_gray_o, full_o, afull_o, wcount_o, overflow_o}, 32'd0);
    endtask

    // Scoreboard monitor: registered outputs are stable at the negedge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tot++;
            if ({wptr_gray_o, waddr_o, full_o, afull_o, wcount_o, overflow_o} ===
                {e.gray, e.waddr, e.full, e.afull, e.wcount, e.ovf}) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got gray=%b waddr=%0d full=%b afull=%b wcount=%0d ovf=%b expected gray=%b waddr=%0d full=%b afull=%b wcount=%0d ovf=%b",
                         e.name, wptr_gray_o, waddr_o, full_o, afull_o, wcount_o, overflow_o,
                         e.gray, e.waddr, e.full, e.afull, e.wcount, e.ovf);
            end
            if (e.chk1) begin
                n_tot++;
                if ($countones(prev_gray ^ wptr_gray_o) <= 1) n_pass++;
                else $display("FAIL %s gray step: got %b -> %b expected at most one bit change",
                              e.name, prev_gray, wptr_gray_o);
            end
        end
        prev_gray = wptr_gray_o;
    end

    task automatic step(input string nm, input logic push, input logic [2:0] rg, input logic ini,
                        input logic ewen, input logic [2:0] eg, input logic [1:0] ea,
                        input logic ef, input logic eaf, input logic [2:0] ec, input logic eo,
                        input bit c1);
        exp_t e;
        @(negedge clk);
        #1;
        push_i = push; rptr_gray_i = rg; init_n = ini;
        #1;
        chk({nm, " wen"}, {31'd0, wen_o}, {31'd0, ewen});
        @(posedge clk);
        e.name = nm; e.gray = eg; e.waddr = ea; e.full = ef; e.afull = eaf;
        e.wcount = ec; e.ovf = eo; e.chk1 = c1;
        q.push_back(e);
    endtask

    // Mid-cycle async reset pulse with an immediate all-zero check.
    task automatic rst_pulse(input string nm);
        @(negedge clk);
        #3;
        push_i = 1'b0; init_n = 1'b1; rptr_gray_i = 3'b000;
        rst = 1'b1;
        #1;
        chk_zero(nm);
        #1;
        rst = 1'b0;
    endtask

    localparam logic [2:0] WG [8] = '{3'b111, 3'b101, 3'b100, 3'b000, 3'b001, 3'b011, 3'b010, 3'b110};
    localparam logic [2:0] RG [8] = '{3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};

    initial begin
        #3;
        chk_zero("power-on reset");
        @(negedge clk);
        rst = 1'b0;

        //         name     push rptr   ini wen gray    wa   f  af cnt   ovf c1
        step("rst push1",   1, 3'b000, 1, 1, 3'b001, 2'd1, 0, 0, 3'd1, 0, 1);
        step("rst push2",   1, 3'b000, 1, 1, 3'b011, 2'd2, 0, 0, 3'd2, 0, 1);
        step("rst push3",   1, 3'b000, 1, 1, 3'b010, 2'd3, 0, 1, 3'd3, 0, 1);
        rst_pulse("mid-stream rst");
        step("post-rst push", 1, 3'b000, 1, 1, 3'b001, 2'd1, 0, 0, 3'd1, 0, 0);

        rst_pulse("pre-fill rst");
        step("fill1",       1, 3'b000, 1, 1, 3'b001, 2'd1, 0, 0, 3'd1, 0, 0);
        step("fill2",       1, 3'b000, 1, 1, 3'b011, 2'd2, 0, 0, 3'd2, 0, 1);
        step("fill3",       1, 3'b000, 1, 1, 3'b010, 2'd3, 0, 1, 3'd3, 0, 1);
        step("fill4",       1, 3'b000, 1, 1, 3'b110, 2'd0, 1, 1, 3'd4, 0, 1);
        step("overflow1",   1, 3'b000, 1, 0, 3'b110, 2'd0, 1, 1, 3'd4, 1, 1);
        step("overflow2",   1, 3'b000, 1, 0, 3'b110, 2'd0, 1, 1, 3'd4, 1, 1);
        step("drain",       0, 3'b001, 1, 0, 3'b110, 2'd0, 0, 1, 3'd3, 0, 1);
        for (int k = 0; k < 8; k++) begin
            step($sformatf("wrap%0d", k + 1), 1, RG[k], 1, 1, WG[k], 2'((k + 1) % 4),
                 0, 1, 3'd3, 0, 1);
        end

        // wbin=4, rbin=1: one more push fills, then a push races a read.
        step("refill",      1, 3'b001, 1, 1, 3'b111, 2'd1, 1, 1, 3'd4, 0, 1);
        step("simul reject",1, 3'b011, 1, 0, 3'b111, 2'd1, 0, 1, 3'd3, 1, 1);
        step("simul accept",1, 3'b011, 1, 1, 3'b101, 2'd2, 1, 1, 3'd4, 0, 1);

        rst_pulse("pre-init rst");
        step("init fill1",  1, 3'b000, 1, 1, 3'b001, 2'd1, 0, 0, 3'd1, 0, 0);
        step("init fill2",  1, 3'b000, 1, 1, 3'b011, 2'd2, 0, 0, 3'd2, 0, 1);
        step("init_n clr",  1, 3'b000, 0, 0, 3'b000, 2'd0, 0, 0, 3'd0, 0, 0);
        step("post-init",   1, 3'b000, 1, 1, 3'b001, 2'd1, 0, 0, 3'd1, 0, 1);

        @(negedge clk);
        #1;
        push_i = 1'b0;
        @(negedge clk);
        #1;
        chk("scoreboard drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
